// File: rtl/load_store_unit.sv
// Load/store back end: runs one req/ack bus transaction per memory op and stalls the core until it completes.
// Optional build macro MISALIGN_TRAP_EN: misaligned half/word accesses skip the bus and pulse misaligned.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        memory_read,
  input  logic        memory_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        bus_error,
  output logic        misaligned,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t             state, state_nx;
  logic               op_we;
  logic [2:0]         f3;
  logic [1:0]         lane;
  logic [CNT_W-1:0]   cnt;
  logic               req, mis_nx, tmo;
  logic [3:0]         wstrb_nx;
  logic [31:0]        wdata_nx, ld;
  logic [7:0]         ld_b;
  logic [15:0]        ld_h;

  assign req     = memory_read | memory_write;
  assign bus_req = (state == REQ);
  assign stall   = ((state == IDLE) && req) || (state == REQ);
  assign tmo     = (TIMEOUT_CYCLES != 0) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MISALIGN_TRAP_EN
  assign mis_nx = ((funct3[1:0] == 2'b01) && address[0]) ||
                  (funct3[1] && (address[1:0] != 2'b00));
`else
  assign mis_nx = 1'b0;
`endif

  // Store lane replication; strobes only on writes so reads present 0000.
  always_comb begin
    wstrb_nx = 4'b1111;
    wdata_nx = write_data;
    case (funct3[1:0])
      2'b00: begin
        wstrb_nx = 4'b0001 << address[1:0];
        wdata_nx = {4{write_data[7:0]}};
      end
      2'b01: begin
        wstrb_nx = address[1] ? 4'b1100 : 4'b0011;
        wdata_nx = {2{write_data[15:0]}};
      end
      default: ;
    endcase
    if (!memory_write) wstrb_nx = 4'b0000;
  end

  always_comb begin
    ld_b = 8'h00;
    case (lane)
      2'd0: ld_b = bus_rdata[7:0];
      2'd1: ld_b = bus_rdata[15:8];
      2'd2: ld_b = bus_rdata[23:16];
      2'd3: ld_b = bus_rdata[31:24];
      default: ;
    endcase
    ld_h = lane[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (f3[1:0])
      2'b00:   ld = f3[2] ? {24'h0, ld_b} : {{24{ld_b[7]}}, ld_b};
      2'b01:   ld = f3[2] ? {16'h0, ld_h} : {{16{ld_h[15]}}, ld_h};
      default: ld = bus_rdata;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (req) state_nx = mis_nx ? DONE : REQ;
      REQ:     if (bus_ack || tmo) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      op_we      <= 1'b0;
      f3         <= 3'b000;
      lane       <= 2'b00;
      cnt        <= '0;
      read_data  <= 32'h0;
      bus_we     <= 1'b0;
      bus_addr   <= 32'h0;
      bus_wdata  <= 32'h0;
      bus_wstrb  <= 4'h0;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
    end else begin
      state      <= state_nx;
      bus_error  <= 1'b0;
      misaligned <= 1'b0;
      case (state)
        IDLE: if (req) begin
          op_we     <= memory_write;
          f3        <= funct3;
          lane      <= address[1:0];
          bus_we    <= memory_write;
          bus_addr  <= {address[31:2], 2'b00};
          bus_wdata <= wdata_nx;
          bus_wstrb <= wstrb_nx;
          cnt       <= '0;
          if (mis_nx) begin
            misaligned <= 1'b1;
            read_data  <= 32'h0;
          end
        end
        REQ: begin
          // Ack wins over a timeout landing in the same cycle.
          if (bus_ack) begin
            cnt <= '0;
            if (!op_we) read_data <= ld;
          end else if (tmo) begin
            cnt       <= '0;
            bus_error <= 1'b1;
            read_data <= 32'h0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: directed ops push expected bus beats and completions; a monitor checks them.
module tb_load_store_unit;
  logic        clk = 1'b0, reset = 1'b1;
  logic        memory_read = 1'b0, memory_write = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] address = 32'h0, write_data = 32'h0;
  logic [31:0] read_data;
  logic        stall, bus_error, misaligned, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  typedef struct { logic [31:0] addr; logic [31:0] wdata; logic [3:0] strb; logic we; } bus_exp_t;
  typedef struct { logic [31:0] rdata; logic err; logic mis; int stall_cyc; } done_exp_t;

  bus_exp_t  bus_q[$];
  done_exp_t done_q[$];
  int checks = 0, errors = 0;
  int scnt = 0;

  load_store_unit #(.TIMEOUT_CYCLES(16), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .memory_read(memory_read), .memory_write(memory_write),
    .funct3(funct3), .address(address), .write_data(write_data), .read_data(read_data),
    .stall(stall), .bus_error(bus_error), .misaligned(misaligned), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // Monitor: bus beats on req&ack, completions when stall falls.
  always @(negedge clk) begin : mon
    bus_exp_t  b;
    done_exp_t d;
    if (bus_req && bus_ack) begin
      if (bus_q.size() == 0) chk("bus_unexpected", 32'd1, 32'd0);
      else begin
        b = bus_q.pop_front();
        chk("bus_addr", bus_addr, b.addr);
        chk("bus_wdata", bus_wdata, b.wdata);
        chk("bus_wstrb", {28'h0, bus_wstrb}, {28'h0, b.strb});
        chk("bus_we", {31'h0, bus_we}, {31'h0, b.we});
      end
    end
    if (stall) scnt++;
    else if (scnt > 0) begin
      if (done_q.size() == 0) chk("done_unexpected", 32'd1, 32'd0);
      else begin
        d = done_q.pop_front();
        chk("read_data", read_data, d.rdata);
        chk("bus_error", {31'h0, bus_error}, {31'h0, d.err});
        chk("misaligned", {31'h0, misaligned}, {31'h0, d.mis});
        chk("stall_cycles", scnt, d.stall_cyc);
      end
      scnt = 0;
    end
  end

  // dly < 0 means never ack; ack otherwise asserted in REQ cycle dly+1.
  task automatic op(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                    input logic [31:0] rd, input int dly, input bit exp_bus,
                    input logic [31:0] e_addr, input logic [31:0] e_wd, input logic [3:0] e_strb,
                    input logic [31:0] e_rd, input logic e_err, input logic e_mis, input int e_stall);
    bus_exp_t  b;
    done_exp_t d;
    int n;
    if (exp_bus) begin
      b.addr = e_addr; b.wdata = e_wd; b.strb = e_strb; b.we = w;
      bus_q.push_back(b);
    end
    d.rdata = e_rd; d.err = e_err; d.mis = e_mis; d.stall_cyc = e_stall;
    done_q.push_back(d);
    @(posedge clk); #1;
    memory_read = ~w; memory_write = w; funct3 = f3; address = a; write_data = wd;
    @(posedge clk); #1;
    memory_read = 1'b0; memory_write = 1'b0;
    if (dly >= 0) begin
      repeat (dly) begin @(posedge clk); #1; end
      bus_ack = 1'b1; bus_rdata = rd;
      @(posedge clk); #1;
      bus_ack = 1'b0;
    end
    n = 0;
    while (stall && n < 40) begin @(posedge clk); #1; n++; end
    if (n >= 40) chk("op_timeout", 32'd1, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    done_exp_t d;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rst_stall", {31'h0, stall}, 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_wstrb", {28'h0, bus_wstrb}, 32'h0);
    chk("rst_bus_error", {30'h0, bus_error, misaligned}, 32'h0);

    // SW, zero-wait ack
    op(1'b1, 3'b010, 32'h104, 32'hDEADBEEF, 32'h0, 0, 1, 32'h104, 32'hDEADBEEF, 4'b1111, 32'h0, 0, 0, 2);
    // SB lane 3, ack on third REQ cycle
    op(1'b1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 2, 1, 32'h200, 32'hA5A5A5A5, 4'b1000, 32'h0, 0, 0, 4);
    // LB / LBU / LHU at 0x302
    op(1'b0, 3'b000, 32'h302, 32'h0, 32'h12F45678, 0, 1, 32'h300, 32'h0, 4'b0000, 32'hFFFFFFF4, 0, 0, 2);
    op(1'b0, 3'b100, 32'h302, 32'h0, 32'h12F45678, 0, 1, 32'h300, 32'h0, 4'b0000, 32'h000000F4, 0, 0, 2);
    op(1'b0, 3'b101, 32'h302, 32'h0, 32'h12F45678, 0, 1, 32'h300, 32'h0, 4'b0000, 32'h000012F4, 0, 0, 2);
    // LH sign-extend low half, one wait state
    op(1'b0, 3'b001, 32'h300, 32'h0, 32'h00008001, 1, 1, 32'h300, 32'h0, 4'b0000, 32'hFFFF8001, 0, 0, 3);
    // SH upper half: read_data untouched
    op(1'b1, 3'b001, 32'h302, 32'h1234ABCD, 32'h0, 0, 1, 32'h300, 32'hABCDABCD, 4'b1100, 32'hFFFF8001, 0, 0, 2);
    // Reserved funct3 011 store acts as SW
    op(1'b1, 3'b011, 32'h40C, 32'h01020304, 32'h0, 0, 1, 32'h40C, 32'h01020304, 4'b1111, 32'hFFFF8001, 0, 0, 2);
    // LW with no ack: 16 REQ cycles then bus_error
    op(1'b0, 3'b010, 32'h400, 32'h0, 32'h0, -1, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 1, 0, 17);
`ifdef MISALIGN_TRAP_EN
    op(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, -1, 0, 32'h0, 32'h0, 4'b0000, 32'h0, 0, 1, 1);
`else
    op(1'b0, 3'b010, 32'h101, 32'h0, 32'hCAFEF00D, 0, 1, 32'h100, 32'h0, 4'b0000, 32'hCAFEF00D, 0, 0, 2);
`endif

    // Reset in second REQ cycle, late ack afterwards
    d.rdata = 32'h0; d.err = 1'b0; d.mis = 1'b0; d.stall_cyc = 3;
    done_q.push_back(d);
    @(posedge clk); #1;
    memory_read = 1'b1; funct3 = 3'b010; address = 32'h500;
    @(posedge clk); #1;
    memory_read = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bus_ack = 1'b1; bus_rdata = 32'h55AA55AA;
    chk("rstmid_bus_req", {31'h0, bus_req}, 32'h0);
    chk("rstmid_read_data", read_data, 32'h0);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    chk("late_ack_bus_req", {31'h0, bus_req}, 32'h0);
    chk("late_ack_stall", {31'h0, stall}, 32'h0);
    chk("late_ack_read_data", read_data, 32'h0);

    repeat (3) @(posedge clk);
    #1;
    chk("bus_q_drained", bus_q.size(), 32'd0);
    chk("done_q_drained", done_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sequential back end for the decoder's memory_read / memory_write control outputs.
- Takes one load or store from the core datapath and runs a req/ack transaction on the data bus. Stalls the pipeline until that transaction completes.
- Handles byte, half and word sizing, write strobes, load sign/zero extension and bus timeout.

Parameters:
- TIMEOUT_CYCLES, 16: REQ cycles without bus_ack before abort; 0 disables timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT_CYCLES < 2^CNT_W.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high.
- memory_read  input  1  load request from control unit.
- memory_write  input  1  store request from control unit.
- funct3  input  3  size/sign: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; stores use 000/001/010.
- address  input  32  byte address from ALU.
- write_data  input  32  store data (rs2).
- read_data  output  32  extended load result.
- stall  output  1  hold pipeline.
- bus_error  output  1  one-cycle pulse, timeout abort.
- misaligned  output  1  one-cycle pulse, misaligned abort (see Optional Feature).
- bus_req  output  1  bus request.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word address {address[31:2],2'b00}.
- bus_wdata  output  32  lane-replicated store data.
- bus_wstrb  output  4  byte enables (0000 on reads).
- bus_ack  input  1  bus completion; rdata valid same cycle.
- bus_rdata  input  32  bus read word.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: state IDLE; read_data, bus_addr, bus_wdata, bus_wstrb, bus_req, bus_we, bus_error, misaligned, timeout counter all 0.
- FSM states are IDLE, REQ, DONE.
- IDLE:
  - On memory_read|memory_write, register address, write_data, funct3 and op, then go to REQ.
  - If both are high, treat as write.
- REQ:
  - bus_req=1; bus_we, bus_addr, bus_wdata and bus_wstrb stay stable until ack.
  - Counter increments each cycle.
  - On bus_ack, capture data, go to DONE, clear counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 without ack, go to DONE with bus_error=1 and read_data=0.
- DONE:
  - bus_req=0; stall=0; bus_error/misaligned pulse here only.
  - Always go to IDLE next cycle; the core advances on this edge.
- stall = (IDLE & (memory_read|memory_write)) | REQ. Combinational; never high in DONE.
- Minimum latency, request seen to stall low: 2 cycles with zero-wait ack (IDLE, REQ+ack, DONE).
- Store sizing:
  - SB: wstrb = 0001 << address[1:0], wdata = {4{byte}}.
  - SH: wstrb = address[1] ? 1100 : 0011, wdata = {2{half}}.
  - SW: wstrb = 1111.
- Load extraction:
  - LB/LBU select lane address[1:0]; LH/LHU select half address[1]; sign- or zero-extend to 32.
  - LW passes the word through.
  - Reserved funct3 (011, 110, 111) behaves as LW/SW.
- read_data holds its value until the next load completes. Stores do not modify read_data.
- bus_ack outside REQ is ignored.
- Reset mid-REQ: bus_req drops the cycle after reset is sampled; a late ack is ignored.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - Halfword with address[0]=1, or word with address[1:0]≠00, skips the bus entirely: IDLE→DONE.
  - misaligned=1 for that DONE cycle; read_data=0; stall high for exactly the IDLE cycle.
- Not defined:
  - misaligned tied 0.
  - Low bits are ignored per sizing rules: LH uses address[1] only; LW ignores address[1:0].

Test Plan:
- SW addr 0x104, data 0xDEADBEEF, ack on first REQ cycle → bus_addr 0x104, wstrb 1111, wdata 0xDEADBEEF, stall high 2 cycles, read_data unchanged.
- SB addr 0x203, data 0x000000A5 → wstrb 1000, wdata 0xA5A5A5A5; bus_req held 3 cycles until a delayed ack.
- LB addr 0x302, bus_rdata 0x12F4_5678 → read_data 0xFFFFFFF4. LBU at same address → 0x000000F4. LHU addr 0x302 → 0x000012F4.
- LW with no ack, TIMEOUT_CYCLES=16 → bus_req high 16 cycles, then DONE with bus_error=1 pulse, read_data 0, stall drops.
- Reset asserted in the 2nd REQ cycle, ack one cycle later → bus_req 0 after reset edge, state IDLE, read_data 0, ack ignored.
- With MISALIGN_TRAP_EN: LW addr 0x101 → no bus_req, misaligned pulse, read_data 0. Without it: bus_addr 0x100 and read_data = full word.
